// File: rtl/wb_ctrl_pkg.sv
// Shared types and encodings for the write-back controller.
// Register addresses are 5 bits wide, so REG_NUM must not exceed 32.
package wb_ctrl_pkg;
  localparam int RegNum       = 32;
  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;

  typedef logic [RegWidth-1:0]     RegBus;
  typedef logic [RegAddrWidth-1:0] RegAddrBus;

  localparam RegAddrBus NOPAddr  = '0;
  localparam RegBus     ZeroWord = '0;
  localparam logic      True     = 1'b1;
  localparam logic      False    = 1'b0;

  typedef enum logic [1:0] {
    WbSrcNone = 2'd0,
    WbSrcLoad = 2'd1,
    WbSrcHold = 2'd2,
    WbSrcEx   = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic      vld;
    RegAddrBus addr;
    RegBus     data;
  } wb_req_t;

  function automatic logic is_nop(input RegAddrBus a);
    return a == NOPAddr;
  endfunction
endpackage

// File: rtl/wb_ctrl_if.sv
// Bundle of the execute/load/issue inputs, the scoreboard queries and the register-file write port.
interface wb_ctrl_if;
  import wb_ctrl_pkg::*;

  logic      ex_valid;
  logic      ex_ready;
  RegAddrBus ex_waddr;
  RegBus     ex_wdata;
  logic      load_valid;
  RegAddrBus load_waddr;
  RegBus     load_wdata;
  logic      issue_valid;
  RegAddrBus issue_waddr;
  RegAddrBus pend_raddr1, pend_raddr2, pend_raddr3;
  logic      pend1, pend2, pend3;
  logic      we;
  RegAddrBus waddr;
  RegBus     wdata;
  logic      sb_err;

  modport master (
    output ex_valid, ex_waddr, ex_wdata, load_valid, load_waddr, load_wdata,
           issue_valid, issue_waddr, pend_raddr1, pend_raddr2, pend_raddr3,
    input  ex_ready, pend1, pend2, pend3, we, waddr, wdata, sb_err
  );

  modport slave (
    input  ex_valid, ex_waddr, ex_wdata, load_valid, load_waddr, load_wdata,
           issue_valid, issue_waddr, pend_raddr1, pend_raddr2, pend_raddr3,
    output ex_ready, pend1, pend2, pend3, we, waddr, wdata, sb_err
  );
endinterface

// File: rtl/wb_scoreboard.sv
// Per-register pending bits: set on issue, cleared by the write that lands on the register file.
module wb_scoreboard
  import wb_ctrl_pkg::*;
#(
  parameter int REG_NUM = RegNum
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_valid,
  input  RegAddrBus issue_waddr,
  input  logic      wr_en,
  input  RegAddrBus wr_addr,
  input  RegAddrBus raddr1,
  input  RegAddrBus raddr2,
  input  RegAddrBus raddr3,
  output logic      pend1,
  output logic      pend2,
  output logic      pend3,
  output logic      sb_err
);
  logic [REG_NUM-1:0] pend, set_mask, clr_mask, pend_n;
  logic               issue_hit, err_hit;

  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    issue_hit = issue_valid && !is_nop(issue_waddr);
    if (issue_hit) set_mask[issue_waddr] = 1'b1;
    if (wr_en)     clr_mask[wr_addr]     = 1'b1;
    // set is applied after clear so a same-cycle issue keeps the bit
    pend_n    = (pend & ~clr_mask) | set_mask;
    pend_n[0] = 1'b0;
    err_hit   = issue_hit && pend[issue_waddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= '0;
      sb_err <= False;
    end else begin
      pend <= pend_n;
      if (err_hit) sb_err <= True;
    end
  end

  assign pend1 = !is_nop(raddr1) && pend[raddr1];
  assign pend2 = !is_nop(raddr2) && pend[raddr2];
  assign pend3 = !is_nop(raddr3) && pend[raddr3];
endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: load > hold > execute arbitration onto a registered register-file write port.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int REG_NUM = RegNum
) (
  input logic    clk,
  input logic    rst,
  wb_ctrl_if.slave bus
);
  wb_src_e   src;
  wb_req_t   sel, hold;
  logic      accept, wr_en;
  logic      we_q;
  RegAddrBus waddr_q;
  RegBus     wdata_q;

  always_comb begin
    accept = bus.ex_valid && !hold.vld;
    src    = WbSrcNone;
    if (bus.load_valid)  src = WbSrcLoad;
    else if (hold.vld)   src = WbSrcHold;
    else if (accept)     src = WbSrcEx;
    sel = '0;
    unique case (src)
      WbSrcLoad: sel = '{vld: True, addr: bus.load_waddr, data: bus.load_wdata};
      WbSrcHold: sel = hold;
      WbSrcEx:   sel = '{vld: True, addr: bus.ex_waddr, data: bus.ex_wdata};
      default:   sel = '0;
    endcase
    // x0 destinations consume their slot but never reach the register file
    wr_en = sel.vld && !is_nop(sel.addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      we_q    <= False;
      waddr_q <= NOPAddr;
      wdata_q <= ZeroWord;
    end else begin
      if (src == WbSrcLoad && accept)
        hold <= '{vld: True, addr: bus.ex_waddr, data: bus.ex_wdata};
      else if (src == WbSrcHold)
        hold.vld <= False;
      we_q    <= wr_en;
      waddr_q <= wr_en ? sel.addr : NOPAddr;
      wdata_q <= wr_en ? sel.data : ZeroWord;
    end
  end

  assign bus.ex_ready = !hold.vld;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;

  wb_scoreboard #(.REG_NUM(REG_NUM)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(bus.issue_valid),
    .issue_waddr(bus.issue_waddr),
    .wr_en      (wr_en),
    .wr_addr    (sel.addr),
    .raddr1     (bus.pend_raddr1),
    .raddr2     (bus.pend_raddr2),
    .raddr3     (bus.pend_raddr3),
    .pend1      (bus.pend1),
    .pend2      (bus.pend2),
    .pend3      (bus.pend3),
    .sb_err     (bus.sb_err)
  );
endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench: expected writes go into a queue, a negedge monitor pops them as we asserts.
module tb_wb_ctrl;
  import wb_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_ctrl_if bus();
  wb_ctrl #(.REG_NUM(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid    = 1'b0;
    bus.ex_waddr    = 5'd0;
    bus.ex_wdata    = 32'h0;
    bus.load_valid  = 1'b0;
    bus.load_waddr  = 5'd0;
    bus.load_wdata  = 32'h0;
    bus.issue_valid = 1'b0;
    bus.issue_waddr = 5'd0;
  endtask

  task automatic drive_ex(input logic [4:0] a, input logic [31:0] d);
    bus.ex_valid = 1'b1;
    bus.ex_waddr = a;
    bus.ex_wdata = d;
  endtask

  task automatic drive_load(input logic [4:0] a, input logic [31:0] d);
    bus.load_valid = 1'b1;
    bus.load_waddr = a;
    bus.load_wdata = d;
  endtask

  task automatic drive_issue(input logic [4:0] a);
    bus.issue_valid = 1'b1;
    bus.issue_waddr = a;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.we === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", bus.waddr, bus.wdata);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(bus.waddr), 32'(e.a));
        chk("wr_data", bus.wdata, e.d);
      end
    end
  end

  initial begin
    idle();
    bus.pend_raddr1 = 5'd0;
    bus.pend_raddr2 = 5'd0;
    bus.pend_raddr3 = 5'd0;
    rst = 1'b1;
    step();
    step();
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", bus.wdata, 32'h0);
    chk("rst_sb_err", 32'(bus.sb_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);

    // single execute clearing a pending register
    drive_issue(5'd5);
    bus.pend_raddr1 = 5'd5;
    step();
    idle();
    #1;
    chk("pend5_set", 32'(bus.pend1), 32'd1);
    drive_ex(5'd5, 32'hDEAD_BEEF);
    push(5'd5, 32'hDEAD_BEEF);
    bus.pend_raddr2 = 5'd5;
    #1;
    chk("ex_ready_single", 32'(bus.ex_ready), 32'd1);
    chk("pend5_before_wr", 32'(bus.pend2), 32'd1);
    step();
    idle();
    #1;
    chk("single_we", 32'(bus.we), 32'd1);
    chk("pend5_cleared", 32'(bus.pend2), 32'd0);

    // load/execute collision
    drive_load(5'd3, 32'h11);
    drive_ex(5'd4, 32'h22);
    push(5'd3, 32'h11);
    push(5'd4, 32'h22);
    step();
    idle();
    #1;
    chk("coll_ex_ready_c2", 32'(bus.ex_ready), 32'd0);
    chk("coll_waddr_c2", 32'(bus.waddr), 32'd3);
    step();
    chk("coll_waddr_c3", 32'(bus.waddr), 32'd4);
    chk("coll_ex_ready_c3", 32'(bus.ex_ready), 32'd1);

    // four-load burst with execute waiting in hold
    drive_ex(5'd7, 32'h77);
    for (int i = 0; i < 4; i++) begin
      drive_load(5'(10 + i), 32'hA0 + 32'(i));
      push(5'(10 + i), 32'hA0 + 32'(i));
      step();
      bus.ex_valid = 1'b0;
      #1;
      chk("burst_ex_ready_low", 32'(bus.ex_ready), 32'd0);
    end
    push(5'd7, 32'h77);
    idle();
    #1;
    chk("burst_ex_ready_c5", 32'(bus.ex_ready), 32'd0);
    step();
    chk("burst_hold_waddr", 32'(bus.waddr), 32'd7);
    chk("burst_ex_ready_c6", 32'(bus.ex_ready), 32'd1);
    step();
    chk("idle_we", 32'(bus.we), 32'd0);

    // x0 destination and issue to x0
    drive_ex(5'd0, 32'h1234);
    step();
    idle();
    chk("x0_we", 32'(bus.we), 32'd0);
    chk("x0_waddr", 32'(bus.waddr), 32'd0);
    chk("x0_wdata", bus.wdata, 32'h0);
    drive_issue(5'd0);
    bus.pend_raddr1 = 5'd0;
    step();
    idle();
    #1;
    chk("x0_pend", 32'(bus.pend1), 32'd0);
    chk("x0_sb_err", 32'(bus.sb_err), 32'd0);

    // same-cycle issue and write: set wins
    drive_issue(5'd9);
    drive_ex(5'd9, 32'h99);
    push(5'd9, 32'h99);
    bus.pend_raddr3 = 5'd9;
    step();
    idle();
    #1;
    chk("x9_set_wins", 32'(bus.pend3), 32'd1);
    chk("x9_no_err", 32'(bus.sb_err), 32'd0);
    drive_issue(5'd9);
    step();
    idle();
    #1;
    chk("waw_sb_err", 32'(bus.sb_err), 32'd1);
    drive_load(5'd9, 32'h9A);
    push(5'd9, 32'h9A);
    step();
    idle();
    #1;
    chk("x9_cleared", 32'(bus.pend3), 32'd0);
    chk("sb_err_sticky1", 32'(bus.sb_err), 32'd1);
    step();
    chk("sb_err_sticky2", 32'(bus.sb_err), 32'd1);

    // reset with hold full and pend = 0x6
    drive_issue(5'd1);
    step();
    drive_issue(5'd2);
    step();
    idle();
    drive_load(5'd20, 32'h2020);
    drive_ex(5'd21, 32'h2121);
    push(5'd20, 32'h2020);
    bus.pend_raddr1 = 5'd1;
    bus.pend_raddr2 = 5'd2;
    step();
    idle();
    #1;
    chk("pre_rst_hold", 32'(bus.ex_ready), 32'd0);
    chk("pre_rst_pend1", 32'(bus.pend1), 32'd1);
    chk("pre_rst_pend2", 32'(bus.pend2), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.we), 32'd0);
    chk("mid_rst_waddr", 32'(bus.waddr), 32'd0);
    chk("mid_rst_wdata", bus.wdata, 32'h0);
    chk("mid_rst_pend1", 32'(bus.pend1), 32'd0);
    chk("mid_rst_pend2", 32'(bus.pend2), 32'd0);
    chk("mid_rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    chk("mid_rst_sb_err", 32'(bus.sb_err), 32'd0);
    step();
    chk("hold_discarded", 32'(bus.we), 32'd0);
    step();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
